// File: rtl/mem_req_ctrl.sv
// Request/response front end for a single-port-style memory: one outstanding
// request, range checking, fixed-latency reads and saturating completion counters.
module mem_req_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_ADR    = 100,
   parameter int ADDRSIZE   = $clog2(MAX_ADR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDRSIZE-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_err,
   output logic                  rd_en,
   output logic [ADDRSIZE-1:0]   rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wr_en,
   output logic [ADDRSIZE-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [15:0]           rd_cnt,
   output logic [15:0]           wr_cnt
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR   = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_CAP  = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   // One extra bit so a limit of exactly 2**ADDRSIZE is still representable.
   localparam logic [ADDRSIZE:0] ADR_LIMIT = (ADDRSIZE+1)'(MAX_ADR);

   logic [2:0]            state_reg;
   logic                  rd_en_reg;
   logic                  wr_en_reg;
   logic [ADDRSIZE-1:0]   rd_addr_reg;
   logic [ADDRSIZE-1:0]   wr_addr_reg;
   logic [DATA_WIDTH-1:0] wr_data_reg;
   logic [DATA_WIDTH-1:0] resp_data_reg;
   logic                  resp_err_reg;
   logic [15:0]           rd_cnt_reg;
   logic [15:0]           wr_cnt_reg;
   logic                  addr_bad;

   assign addr_bad = ({1'b0, req_addr} >= ADR_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         rd_en_reg     <= 1'b0;
         wr_en_reg     <= 1'b0;
         rd_addr_reg   <= '0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
         resp_data_reg <= '0;
         resp_err_reg  <= 1'b0;
         rd_cnt_reg    <= '0;
         wr_cnt_reg    <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (req_valid) begin
                  resp_data_reg <= '0;
                  if (addr_bad) begin
                     resp_err_reg <= 1'b1;
                     state_reg    <= S_RESP;
                  end else if (req_we) begin
                     resp_err_reg <= 1'b0;
                     wr_en_reg    <= 1'b1;
                     wr_addr_reg  <= req_addr;
                     wr_data_reg  <= req_wdata;
                     state_reg    <= S_WR;
                  end else begin
                     resp_err_reg <= 1'b0;
                     rd_en_reg    <= 1'b1;
                     rd_addr_reg  <= req_addr;
                     state_reg    <= S_RD;
                  end
               end
            end
            S_WR: begin
               wr_en_reg <= 1'b0;
               if (wr_cnt_reg != 16'hFFFF)
                  wr_cnt_reg <= wr_cnt_reg + 16'd1;
               state_reg <= S_RESP;
            end
            S_RD: begin
               // Memory registers rd_data on this edge; it is captured one edge later.
               rd_en_reg <= 1'b0;
               state_reg <= S_CAP;
            end
            S_CAP: begin
               resp_data_reg <= rd_data;
               resp_err_reg  <= 1'b0;
               if (rd_cnt_reg != 16'hFFFF)
                  rd_cnt_reg <= rd_cnt_reg + 16'd1;
               state_reg <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready)
                  state_reg <= S_IDLE;
            end
            default: begin
               rd_en_reg <= 1'b0;
               wr_en_reg <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_reg == S_IDLE);
   assign resp_valid = (state_reg == S_RESP);
   assign resp_data  = resp_data_reg;
   assign resp_err   = resp_err_reg;
   assign rd_en      = rd_en_reg;
   assign rd_addr    = rd_addr_reg;
   assign wr_en      = wr_en_reg;
   assign wr_addr    = wr_addr_reg;
   assign wr_data    = wr_data_reg;
   assign rd_cnt     = rd_cnt_reg;
   assign wr_cnt     = wr_cnt_reg;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl with a small registered-read memory model.
module tb_mem_req_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [6:0]  req_addr;
   logic [7:0]  req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [7:0]  resp_data;
   logic        resp_err;
   logic        rd_en;
   logic [6:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] rd_cnt;
   logic [15:0] wr_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [0:127];

   always #5 clk = ~clk;

   mem_req_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt)
   );

   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         n_checks++;
         if (rd_en === 1'b1 && wr_en === 1'b1) begin
            n_fail++;
            $display("FAIL excl_rd_wr: rd_en=%b wr_en=%b, required not both 1", rd_en, wr_en);
         end
      end
   end

   // Issue one request from IDLE at a negedge; measure latency and port pulses,
   // hold resp_ready low for 'hold' cycles, then consume the response.
   task automatic run_req(input logic we, input logic [6:0] addr, input logic [7:0] wd,
                          input int hold, output int lat, output logic [7:0] rdat,
                          output logic err, output int rdp, output int wrp);
      logic [7:0] d0;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL req_ready_idle: got %b, required 1", req_ready);
      end
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; rdp = 0; wrp = 0;
      while (resp_valid !== 1'b1 && lat < 10) begin
         rdp += int'(rd_en); wrp += int'(wr_en);
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (lat >= 10) begin
         n_fail++;
         $display("FAIL resp_timeout: no resp_valid after %0d cycles, required within 3", lat);
      end
      rdat = resp_data; err = resp_err; d0 = resp_data;
      $display("txn we=%b addr=%0d wdata=%h lat=%0d data=%h err=%b", we, addr, wd, lat, rdat, err);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_checks++;
         if (resp_valid !== 1'b1 || resp_data !== d0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_hold[%0d]: valid=%b data=%h ready=%b, required 1 %h 0",
                     i, resp_valid, resp_data, req_ready, d0);
         end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL resp_done: valid=%b ready=%b, required 0 1", resp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({req_ready, resp_valid, resp_err, rd_en, wr_en} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready,valid,err,rd_en,wr_en=%b, required 10000",
                  {req_ready, resp_valid, resp_err, rd_en, wr_en});
      end
      n_checks++;
      if (resp_data !== 8'h00 || rd_addr !== 7'd0 || wr_addr !== 7'd0 || wr_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: data=%h rd_addr=%0d wr_addr=%0d wr_data=%h, required all 0",
                  resp_data, rd_addr, wr_addr, wr_data);
      end
      n_checks++;
      if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: rd_cnt=%0d wr_cnt=%0d, required 0 0", rd_cnt, wr_cnt);
      end
      $display("txn reset done");
   endtask

   task automatic test_write_read();
      int lat, rdp, wrp; logic [7:0] d; logic e;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd5; req_wdata = 8'hA5;
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 7'd5 || wr_data !== 8'hA5 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_port: wr_en=%b addr=%0d data=%h valid=%b, required 1 5 a5 0",
                  wr_en, wr_addr, wr_data, resp_valid);
      end
      @(negedge clk);
      n_checks++;
      if (wr_en !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL wr_resp: wr_en=%b valid=%b err=%b data=%h, required 0 1 0 00",
                  wr_en, resp_valid, resp_err, resp_data);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      $display("txn write addr=5 data=a5 wr_cnt=%0d", wr_cnt);
      run_req(1'b0, 7'd5, 8'h00, 0, lat, d, e, rdp, wrp);
      n_checks++;
      if (lat !== 3 || d !== 8'hA5 || e !== 1'b0 || rdp !== 1 || wrp !== 0) begin
         n_fail++;
         $display("FAIL rd_resp: lat=%0d data=%h err=%b rdp=%0d wrp=%0d, required 3 a5 0 1 0",
                  lat, d, e, rdp, wrp);
      end
      n_checks++;
      if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL wr_rd_cnt: wr_cnt=%0d rd_cnt=%0d, required 1 1", wr_cnt, rd_cnt);
      end
   endtask

   task automatic test_error();
      int lat, rdp, wrp; logic [7:0] d; logic e;
      run_req(1'b0, 7'd100, 8'h00, 0, lat, d, e, rdp, wrp);
      n_checks++;
      if (lat !== 1 || e !== 1'b1 || d !== 8'h00 || rdp !== 0 || wrp !== 0) begin
         n_fail++;
         $display("FAIL err_read: lat=%0d err=%b data=%h rdp=%0d wrp=%0d, required 1 1 00 0 0",
                  lat, e, d, rdp, wrp);
      end
      run_req(1'b1, 7'd127, 8'h3C, 0, lat, d, e, rdp, wrp);
      n_checks++;
      if (lat !== 1 || e !== 1'b1 || d !== 8'h00 || wrp !== 0) begin
         n_fail++;
         $display("FAIL err_write: lat=%0d err=%b data=%h wrp=%0d, required 1 1 00 0", lat, e, d, wrp);
      end
      run_req(1'b1, 7'd99, 8'h3C, 0, lat, d, e, rdp, wrp);
      n_checks++;
      if (lat !== 2 || e !== 1'b0 || wrp !== 1) begin
         n_fail++;
         $display("FAIL edge_write99: lat=%0d err=%b wrp=%0d, required 2 0 1", lat, e, wrp);
      end
      n_checks++;
      if (rd_cnt !== 16'd1 || wr_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL err_cnt: rd_cnt=%0d wr_cnt=%0d, required 1 2", rd_cnt, wr_cnt);
      end
   endtask

   task automatic test_resp_hold();
      int lat, rdp, wrp; logic [7:0] d; logic e;
      run_req(1'b0, 7'd99, 8'h00, 4, lat, d, e, rdp, wrp);
      n_checks++;
      if (lat !== 3 || d !== 8'h3C || e !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_read: lat=%0d data=%h err=%b, required 3 3c 0", lat, d, e);
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      logic [15:0] w0, r0;
      w0 = wr_cnt; r0 = rd_cnt;
      acc = 0;
      req_valid = 1'b1; req_we = 1'b1; resp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         req_addr = 7'(10 + i); req_wdata = 8'(i);
         acc += int'(req_ready);
         @(negedge clk);
      end
      req_we = 1'b0;
      for (int i = 0; i < 12; i++) begin
         req_addr = 7'(10 + i);
         acc += int'(req_ready);
         @(negedge clk);
      end
      req_valid = 1'b0; resp_ready = 1'b0;
      $display("txn back_to_back accepts=%0d wr_cnt=%0d rd_cnt=%0d", acc, wr_cnt, rd_cnt);
      n_checks++;
      if (acc !== 7) begin
         n_fail++;
         $display("FAIL b2b_accepts: got %0d, required 7", acc);
      end
      n_checks++;
      if (wr_cnt !== w0 + 16'd4 || rd_cnt !== r0 + 16'd3) begin
         n_fail++;
         $display("FAIL b2b_cnt: wr_cnt=%0d rd_cnt=%0d, required %0d %0d", wr_cnt, rd_cnt, w0 + 16'd4, r0 + 16'd3);
      end
   endtask

   task automatic test_reset_in_rd();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd5;
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++;
      if (rd_en !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_rd_en: rd_en=%b, required 1", rd_en);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (rd_en !== 1'b0 || resp_valid !== 1'b0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL abort_state: rd_en=%b valid=%b rd_cnt=%0d wr_cnt=%0d, required 0 0 0 0",
                  rd_en, resp_valid, rd_cnt, wr_cnt);
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_noresp[%0d]: valid=%b ready=%b, required 0 1", i, resp_valid, req_ready);
         end
      end
      resp_ready = 1'b0;
      $display("txn reset during RD done");
   endtask

   task automatic test_wr_saturation();
      int lat, rdp, wrp; logic [7:0] d; logic e;
      force dut.wr_cnt_reg = 16'hFFFE;
      @(negedge clk);
      release dut.wr_cnt_reg;
      @(negedge clk);
      n_checks++;
      if (wr_cnt !== 16'hFFFE) begin
         n_fail++;
         $display("FAIL sat_preload: wr_cnt=%h, required fffe", wr_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         run_req(1'b1, 7'(20 + i), 8'h55, 0, lat, d, e, rdp, wrp);
         n_checks++;
         if (wr_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_wr[%0d]: wr_cnt=%h, required ffff", i, wr_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_error();
      test_resp_hold();
      test_back_to_back();
      test_reset_in_rd();
      test_wr_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width.
REQ-002 Parameter MAX_ADR, default 100, SHALL set the number of memory words; valid addresses are 0..MAX_ADR-1.
REQ-003 Parameter ADDRSIZE, default $clog2(MAX_ADR), SHALL set the address width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  client request present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDRSIZE  request address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  client consumes the response.
REQ-014 resp_data  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 resp_err  output  1  address out of range, no memory access made.
REQ-016 rd_en, rd_addr  output  1, ADDRSIZE  memory read port.
REQ-017 rd_data  input  DATA_WIDTH  memory read data, registered by the memory on the edge where rd_en=1.
REQ-018 wr_en, wr_addr, wr_data  output  1, ADDRSIZE, DATA_WIDTH  memory write port.
REQ-019 rd_cnt, wr_cnt  output  16 each  completed in-range read and write counts.

Function
REQ-020 The FSM SHALL have states IDLE, WR, RD, CAP and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on a clk edge where req_valid & req_ready are both 1; address, we and wdata SHALL be latched at that edge.
REQ-022 Accepted request with address >= MAX_ADR: next state RESP with resp_err=1 and resp_data=0; rd_en and wr_en SHALL stay 0.
REQ-023 Accepted in-range write: next state WR; in WR, wr_en=1 with the latched wr_addr and wr_data, for exactly one cycle; then RESP with resp_err=0 and resp_data=0.
REQ-024 Accepted in-range read: next state RD; in RD, rd_en=1 with the latched rd_addr, for exactly one cycle.
REQ-025 In CAP, the block SHALL sample rd_data into resp_data; the next state SHALL be RESP with resp_err=0.
REQ-026 Read latency SHALL be fixed: acceptance edge to first resp_valid=1 is 3 cycles; for writes and errors it is 2 cycles and 1 cycle respectively.
REQ-027 rd_en and wr_en SHALL never be 1 in the same cycle, because the memory ignores simultaneous read and write.
REQ-028 All memory port outputs SHALL be registered; rd_en and wr_en SHALL be 0 in every state except RD and WR.
REQ-029 In RESP, resp_valid=1 and resp_data/resp_err SHALL hold stable until a clk edge with resp_ready=1; on that edge the next state SHALL be IDLE.
REQ-030 resp_valid SHALL be 0 outside RESP; resp_ready outside RESP SHALL be ignored.
REQ-031 rd_cnt SHALL increment on leaving CAP; wr_cnt SHALL increment on leaving WR.
REQ-032 Both counters SHALL saturate at 16'hFFFF and not wrap; error responses SHALL NOT count.
REQ-033 Requests presented while req_ready=0 SHALL be neither accepted nor lost; the client holds them per valid/ready rules.

Reset
REQ-034 When rst=1 at a clk edge: state SHALL go to IDLE; req_ready=1 in the following cycle; resp_valid, resp_err, rd_en and wr_en SHALL be 0; resp_data, rd_addr, wr_addr, wr_data, rd_cnt and wr_cnt SHALL be 0.
REQ-035 Reset SHALL take precedence over any transition; a reset asserted in WR or RD SHALL deassert wr_en/rd_en in the next cycle.
REQ-036 After reset, no pending response SHALL be presented.

Verification
REQ-037 Write addr 5 data 8'hA5, then read addr 5 -> wr_en pulse 1 cycle at addr 5; read response resp_data=8'hA5, resp_err=0, 3 cycles after read acceptance; wr_cnt=1, rd_cnt=1.
REQ-038 Read addr 100 with MAX_ADR=100 -> resp_err=1, resp_data=0, 1 cycle after acceptance; no rd_en pulse; counters unchanged.
REQ-039 Read response with resp_ready held 0 for 4 cycles -> resp_valid and resp_data stable all 4 cycles; req_ready=0 throughout; IDLE after the resp_ready=1 edge.
REQ-040 Back-to-back requests with req_valid held 1 and resp_ready=1 -> each accepted only in IDLE; rd_en and wr_en never both 1.
REQ-041 rst asserted during RD -> rd_en=0, resp_valid=0 and counters=0 next cycle; no response is ever presented for the aborted read.
REQ-042 Preload wr_cnt to 16'hFFFE, then issue 3 writes -> wr_cnt reads 16'hFFFF and stays there.
